// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int INS_BYTES = 3;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - byte circular buffer with single-byte push and three-byte pop
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [23:0]                head
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    storage [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_1;
    logic [PW-1:0] rd_ptr_2;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full buffer or a pop of fewer than three bytes is ignored.
    assign push_ok = push && !flush && (count < CW'(DEPTH));
    assign pop_ok  = pop && !flush && (count >= CW'(INS_BYTES));

    // rd_ptr only ever lands on multiples of three, so the three head bytes never wrap.
    assign rd_ptr_1 = rd_ptr + PW'(1);
    assign rd_ptr_2 = rd_ptr + PW'(2);
    assign head     = {storage[rd_ptr_2], storage[rd_ptr_1], storage[rd_ptr]};

    // Byte storage is written without reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the buffer outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - INS_BYTES)) ? '0 : rd_ptr + PW'(INS_BYTES);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(INS_BYTES);
                2'b11:   count <= count - CW'(INS_BYTES - 1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: byte fetcher feeding a 24-bit instruction queue
module ifu
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 6,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        ins_valid,
    output logic [23:0] ins_raw,
    output logic [15:0] ins_pc,
    input  logic        ins_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state;
    logic [15:0]   fetch_pc;
    logic [15:0]   head_pc;
    logic [CW-1:0] count;
    logic [23:0]   head;
    logic          push;
    logic          pop;
    logic          has_room;

    // Only a non-redirected ack of a live request delivers a byte; redirect wins over pop.
    assign push     = (state == REQ) && mem_ack && !redirect;
    assign pop      = ins_valid && ins_ready && !redirect;
    assign has_room = count < CW'(DEPTH);

    assign ins_valid = count >= CW'(INS_BYTES);
    assign ins_raw   = ins_valid ? head : 24'h000000;
    assign ins_pc    = head_pc;

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (mem_rdata),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    // Memory request FSM: one outstanding byte read, stale replies drained after a redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end else if (has_room) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        if (mem_ack) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mem_ack) begin
                        fetch_pc <= fetch_pc + 16'd1;
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Address of the oldest queued byte follows redirects and instruction pops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_pc <= RESET_PC;
        end else if (redirect) begin
            head_pc <= redirect_pc;
        end else if (pop) begin
            head_pc <= head_pc + 16'(INS_BYTES);
        end
    end

endmodule
